// File: rtl/fp_norm_pkg.sv
// Shared constants for the FP add/sub normalise/round path.
package fp_norm_pkg;

  localparam int unsigned ROUND_RNE   = 0;
  localparam int unsigned ROUND_TRUNC = 1;

  localparam int unsigned MANT_IN_W_DEF  = 11;
  localparam int unsigned MANT_OUT_W_DEF = 8;
  localparam int unsigned EXP_W_DEF      = 8;
  localparam int unsigned LZ_W_DEF       = $clog2(MANT_IN_W_DEF + 1);

endpackage

// File: rtl/lzc_param.sv
// Combinational leading-zero counter; count == W when the input is all zeros.
module lzc_param #(
  parameter int unsigned W    = 11,
  parameter int unsigned LZ_W = $clog2(W + 1)
) (
  input  logic [W-1:0]    in,
  output logic [LZ_W-1:0] count,
  output logic            all_zero
);

  // Scan LSB to MSB so the highest set bit has the final say.
  always_comb begin
    count = LZ_W'(W);
    for (int i = 0; i < int'(W); i++) begin
      if (in[i]) count = LZ_W'(int'(W) - 1 - i);
    end
  end

  assign all_zero = ~|in;

endmodule

// File: rtl/lz_norm_pipe.sv
// Three-stage leading-zero normaliser and rounder (count, shift, round) with
// valid/ready flow control per stage.
module lz_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int unsigned MANT_IN_W  = MANT_IN_W_DEF,
  parameter int unsigned MANT_OUT_W = MANT_OUT_W_DEF,
  parameter int unsigned EXP_W      = EXP_W_DEF,
  parameter int unsigned ROUND_MODE = ROUND_RNE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_IN_W-1:0]  in_mant,
  input  logic [EXP_W-1:0]      in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_OUT_W-1:0] out_mant,
  output logic [EXP_W-1:0]      out_exp,
  output logic                  out_zero,
  output logic                  out_uflow,
  output logic                  out_oflow
);

  localparam int unsigned LZ_W  = $clog2(MANT_IN_W + 1);
  localparam int unsigned GRD_W = MANT_IN_W - MANT_OUT_W;
  localparam logic [GRD_W-1:0] S_MASK = GRD_W'((1 << (GRD_W - 1)) - 1);

  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  logic [MANT_IN_W-1:0] s1_mant;
  logic [EXP_W-1:0]     s1_exp;
  logic [LZ_W-1:0]      s1_lz;
  logic                 s1_zero;

  logic [MANT_IN_W-1:0] s2_mant;
  logic [EXP_W-1:0]     s2_exp;
  logic                 s2_zero;
  logic                 s2_uflow;

  logic [LZ_W-1:0] lz_c;
  logic            all_zero_c;

  // Ready chain: a stage may take data when empty or when it drains this cycle.
  assign rdy3      = !v3 || out_ready;
  assign rdy2      = !v2 || rdy3;
  assign rdy1      = !v1 || rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v3;

  lzc_param #(.W(MANT_IN_W), .LZ_W(LZ_W)) u_lzc (
    .in       (in_mant),
    .count    (lz_c),
    .all_zero (all_zero_c)
  );

  // Shift stage; the extra exponent bit carries the borrow for underflow.
  logic [EXP_W:0]       exp_diff_c;
  logic [MANT_IN_W-1:0] n2_mant_c;
  logic [EXP_W-1:0]     n2_exp_c;
  logic                 n2_zero_c;
  logic                 n2_uflow_c;

  always_comb begin
    exp_diff_c = {1'b0, s1_exp} - (EXP_W + 1)'(s1_lz);
    n2_mant_c  = s1_mant << s1_lz;
    n2_exp_c   = exp_diff_c[EXP_W-1:0];
    n2_zero_c  = 1'b0;
    n2_uflow_c = 1'b0;
    if (s1_zero) begin
      n2_mant_c = '0;
      n2_exp_c  = '0;
      n2_zero_c = 1'b1;
    end else if (exp_diff_c[EXP_W]) begin
      n2_mant_c  = '0;
      n2_exp_c   = '0;
      n2_zero_c  = 1'b1;
      n2_uflow_c = 1'b1;
    end
  end

  // Round stage: RNE on guard/sticky, carry-out renormalises, exponent carry saturates.
  logic [MANT_OUT_W-1:0] top_c;
  logic [GRD_W-1:0]      grd_c;
  logic                  inc_c;
  logic [MANT_OUT_W:0]   sum_c;
  logic [EXP_W:0]        exp_inc_c;
  logic [MANT_OUT_W-1:0] n3_mant_c;
  logic [EXP_W-1:0]      n3_exp_c;
  logic                  n3_oflow_c;

  always_comb begin
    top_c      = s2_mant[MANT_IN_W-1 -: MANT_OUT_W];
    grd_c      = s2_mant[GRD_W-1:0];
    inc_c      = (ROUND_MODE == ROUND_RNE) && grd_c[GRD_W-1] &&
                 ((|(grd_c & S_MASK)) || top_c[0]);
    sum_c      = {1'b0, top_c} + (MANT_OUT_W + 1)'(inc_c);
    exp_inc_c  = {1'b0, s2_exp} + (EXP_W + 1)'(1);
    n3_mant_c  = sum_c[MANT_OUT_W-1:0];
    n3_exp_c   = s2_exp;
    n3_oflow_c = 1'b0;
    if (!s2_zero && sum_c[MANT_OUT_W]) begin
      if (exp_inc_c[EXP_W]) begin
        n3_mant_c  = '1;
        n3_exp_c   = '1;
        n3_oflow_c = 1'b1;
      end else begin
        n3_mant_c = MANT_OUT_W'(1) << (MANT_OUT_W - 1);
        n3_exp_c  = exp_inc_c[EXP_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_lz     <= '0;
      s1_zero   <= 1'b0;
      s2_mant   <= '0;
      s2_exp    <= '0;
      s2_zero   <= 1'b0;
      s2_uflow  <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
      out_oflow <= 1'b0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy2) v2 <= v1;
      if (rdy3) v3 <= v2;
      if (in_valid && rdy1) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_lz   <= lz_c;
        s1_zero <= all_zero_c;
      end
      if (v1 && rdy2) begin
        s2_mant  <= n2_mant_c;
        s2_exp   <= n2_exp_c;
        s2_zero  <= n2_zero_c;
        s2_uflow <= n2_uflow_c;
      end
      if (v2 && rdy3) begin
        out_mant  <= n3_mant_c;
        out_exp   <= n3_exp_c;
        out_zero  <= s2_zero;
        out_uflow <= s2_uflow;
        out_oflow <= n3_oflow_c;
      end
    end
  end

endmodule
